// File: rtl/score_digit_if.sv
`default_nettype none
// =============================================================================
// score_digit_if : score load handshake and scanned-digit display bus   Rev 1.0
// =============================================================================
interface score_digit_if #(
  parameter int SCORE_W = 10,
  parameter int DIGITS  = 3
);
  logic [SCORE_W-1:0]  score_in;
  logic                score_load;
  logic                busy;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  logic [3:0]          digit_num;
  logic [DIGITS-1:0]   digit_sel;

  modport master (
    output score_in, score_load,
    input  busy, overflow, bcd_out, digit_num, digit_sel
  );

  modport slave (
    input  score_in, score_load,
    output busy, overflow, bcd_out, digit_num, digit_sel
  );
endinterface
`default_nettype wire

// File: rtl/score_digit_driver.sv
`default_nettype none
// =============================================================================
// score_digit_driver : binary score -> BCD (double dabble), scanned digit drive
// Rev 1.0
// =============================================================================
module score_digit_driver #(
  parameter int SCORE_W  = 10,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  score_digit_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam int SCR_W     = SCORE_W + 4;
  localparam int NIB       = ((SCR_W + 3) / 4 > DIGITS) ? (SCR_W + 3) / 4 : DIGITS;
  localparam int PAD_W     = 4 * NIB;
  localparam int BIT_CNT_W = $clog2(SCORE_W + 1);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAX_VAL   = 10 ** DIGITS - 1;

  logic [1:0]           state_q, state_d;
  logic [SCORE_W-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 overflow_q, overflow_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [3:0]           digit_num_q, digit_num_d;
  logic [DIGITS-1:0]    sel_pre_q, sel_pre_d;
  logic [DIGITS-1:0]    digit_sel_q, digit_sel_d;

  logic [31:0]          score_ext;
  logic [PAD_W-1:0]     scratch_ext;
  logic [PAD_W-1:0]     scratch_adj;
  logic [DIGITS-1:0]    digit_lit;
  logic                 scan_wrap;
  logic                 unused_bits;

  assign score_ext   = 32'(bus.score_in);
  assign scratch_ext = PAD_W'(scratch_q);
  assign unused_bits = ^{scratch_adj[PAD_W-1:SCR_W-1], scratch_ext[PAD_W-1:4*DIGITS]};

  // Add-3 correction on every nibble that would exceed 9 after the shift
  always_comb begin
    scratch_adj = scratch_ext;
    for (int k = 0; k < NIB; k++) begin
      if (scratch_adj[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_adj[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.score_load) begin
          shift_d    = bus.score_in;
          scratch_d  = '0;
          bit_cnt_d  = '0;
          ovf_pend_d = (score_ext > 32'(MAX_VAL));
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {scratch_d, shift_d} = {scratch_adj[SCR_W-2:0], shift_q, 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == BIT_CNT_W'(SCORE_W - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : scratch_ext[4*DIGITS-1:0];
        overflow_d = ovf_pend_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A digit above the units is lit only if it or some higher digit is nonzero
  for (genvar k = 0; k < DIGITS; k++) begin : g_lit
    if (k == 0) begin : g_units
      assign digit_lit[k] = 1'b1;
    end else begin : g_upper
      assign digit_lit[k] = |bcd_q[4*DIGITS-1:4*k];
    end
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_wrap) begin
      scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
    digit_num_d = '0;
    sel_pre_d   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx_d == IDX_W'(k)) begin
        digit_num_d = bcd_q[4*k +: 4];
        if (digit_lit[k]) begin
          sel_pre_d = ~(DIGITS'(1) << k);
        end
      end
    end
    // Select trails the digit code by one cycle to line up with the decoder register
    digit_sel_d = sel_pre_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      bit_cnt_q   <= '0;
      ovf_pend_q  <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      digit_num_q <= '0;
      sel_pre_q   <= '1;
      digit_sel_q <= '1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      bit_cnt_q   <= bit_cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      bcd_q       <= bcd_d;
      overflow_q  <= overflow_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      digit_num_q <= digit_num_d;
      sel_pre_q   <= sel_pre_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overflow  = overflow_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.digit_num = digit_num_q;
  assign bus.digit_sel = digit_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_score_digit_driver.sv
`default_nettype none
// =============================================================================
// tb_score_digit_driver : load vector table, corner sequences, random traffic
// Rev 1.0
// =============================================================================
module tb_score_digit_driver;
  localparam int SCORE_W  = 10;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;
  localparam int MAX_VAL  = 999;
  localparam int NV       = 9;

  typedef struct {
    int          score;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: decimal value on display, countdown to commit, scan position
  int                m_val, m_ovf, m_left, m_pend_val, m_pend_ovf, m_e;
  logic [DIGITS-1:0] m_sel_pend, exp_sel;
  logic [3:0]        exp_num;
  vec_t              vecs [NV];

  always #5 clk = ~clk;

  score_digit_if #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) bus ();

  score_digit_driver #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] sel_of(int v, int idx);
    logic [DIGITS-1:0] one;
    one = 1;
    if (idx > 0 && (v / pow10(idx)) == 0) return '1;
    return ~(one << idx);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    int idx_new;
    @(posedge clk);
    if (!rst_n) begin
      m_e = 0; m_val = 0; m_ovf = 0; m_left = 0;
      m_sel_pend = '1; exp_sel = '1; exp_num = '0;
    end else begin
      m_e++;
      idx_new    = (m_e / SCAN_DIV) % DIGITS;
      exp_num    = 4'((m_val / pow10(idx_new)) % 10);
      exp_sel    = m_sel_pend;
      m_sel_pend = sel_of(m_val, idx_new);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_val = m_pend_val;
          m_ovf = m_pend_ovf;
        end
      end else if (bus.score_load) begin
        m_left     = SCORE_W + 1;
        m_pend_ovf = (int'(bus.score_in) > MAX_VAL) ? 1 : 0;
        m_pend_val = m_pend_ovf ? MAX_VAL : int'(bus.score_in);
      end
    end
    #1;
    chk("busy", bus.busy, (m_left > 0));
    chk("overflow", bus.overflow, m_ovf);
    chk("bcd_out", bus.bcd_out, to_bcd(m_val));
    chk("digit_num", bus.digit_num, exp_num);
    chk("digit_sel", bus.digit_sel, exp_sel);
  endtask

  task automatic load(int v);
    bus.score_in   = SCORE_W'(v);
    bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
  endtask

  // Each lit slot must show the digit from the previous cycle's digit_num
  task automatic observe(logic [11:0] bcd, logic [DIGITS-1:0] exp_lit, string tag);
    logic [3:0]        prev_num;
    logic [DIGITS-1:0] lit, one;
    one      = 1;
    lit      = '0;
    prev_num = bus.digit_num;
    for (int c = 0; c < 2 * SCAN_DIV * DIGITS; c++) begin
      tick();
      for (int k = 0; k < DIGITS; k++) begin
        if (bus.digit_sel == ~(one << k)) begin
          lit[k] = 1'b1;
          chk({tag, "_num"}, prev_num, bcd[4*k +: 4]);
        end
      end
      prev_num = bus.digit_num;
    end
    chk({tag, "_lit"}, lit, exp_lit);
  endtask

  initial begin
    vecs[0] = '{437,  12'h437, 1'b0};
    vecs[1] = '{1023, 12'h999, 1'b1};
    vecs[2] = '{5,    12'h005, 1'b0};
    vecs[3] = '{0,    12'h000, 1'b0};
    vecs[4] = '{999,  12'h999, 1'b0};
    vecs[5] = '{1000, 12'h999, 1'b1};
    vecs[6] = '{250,  12'h250, 1'b0};
    vecs[7] = '{100,  12'h100, 1'b0};
    vecs[8] = '{9,    12'h009, 1'b0};

    bus.score_in   = '0;
    bus.score_load = 1'b0;
    rst_n          = 1'b0;
    repeat (2) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_bcd", bus.bcd_out, 12'h000);
    chk("rst_sel", bus.digit_sel, 3'b111);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < NV; i++) begin
      load(vecs[i].score);
      chk($sformatf("v%0d_busy_T", i), bus.busy, 1);
      repeat (SCORE_W) tick();
      chk($sformatf("v%0d_busy_T10", i), bus.busy, 1);
      tick();
      chk($sformatf("v%0d_bcd", i), bus.bcd_out, vecs[i].bcd);
      chk($sformatf("v%0d_ovf", i), bus.overflow, vecs[i].ovf);
      chk($sformatf("v%0d_busy_end", i), bus.busy, 0);
      repeat (2) tick();
    end

    load(7);    repeat (SCORE_W + 3) tick(); observe(12'h007, 3'b001, "scan7");
    load(0);    repeat (SCORE_W + 3) tick(); observe(12'h000, 3'b001, "scan0");
    load(30);   repeat (SCORE_W + 3) tick(); observe(12'h030, 3'b011, "scan30");
    load(1023); repeat (SCORE_W + 3) tick(); observe(12'h999, 3'b111, "scanovf");
    load(250);  repeat (SCORE_W + 3) tick(); observe(12'h250, 3'b111, "scan250");

    // Load while busy is ignored
    load(437);
    repeat (4) tick();
    bus.score_in   = SCORE_W'(999);
    bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
    chk("ign_busy", bus.busy, 1);
    repeat (6) tick();
    chk("ign_bcd", bus.bcd_out, 12'h437);
    repeat (3) tick();
    chk("ign_bcd_hold", bus.bcd_out, 12'h437);
    chk("ign_idle", bus.busy, 0);

    // Reset mid-conversion abandons it
    load(1023); repeat (SCORE_W + 2) tick();
    load(437);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_bcd", bus.bcd_out, 12'h000);
    chk("abort_ovf", bus.overflow, 0);
    chk("abort_sel", bus.digit_sel, 3'b111);
    tick();
    rst_n = 1'b1;
    repeat (SCORE_W + 3) tick();
    chk("abort_busy_after", bus.busy, 0);
    chk("abort_bcd_after", bus.bcd_out, 12'h000);

    for (int n = 0; n < 600; n++) begin
      bus.score_in   = ($urandom_range(0, 1) == 0) ? SCORE_W'($urandom_range(0, 999))
                                                   : SCORE_W'($urandom_range(0, 1023));
      bus.score_load = ($urandom_range(0, 3) == 0);
      rst_n          = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n          = 1'b1;
    bus.score_load = 1'b0;
    repeat (SCORE_W + 3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
